// File: rtl/im_stage_ctrl.sv
// rtl/im_stage_ctrl.sv - memory-stage controller: data-memory handshake, stall, IM/IW register
module im_stage_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic        MisalignW,
   output logic        TimeoutW
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [31:0] rdata_buf;
   logic        timed_out;
   logic        access;
   logic        aligned;

   assign access  = MemWriteM | (ResultSrcM == 2'b01);
   assign aligned = (ALUResultM[1:0] == 2'b00);

   // Request lines are driven only while in REQ; the M inputs are held stable upstream.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (state == REQ) begin
         mem_req   = 1'b1;
         mem_we    = MemWriteM;
         mem_addr  = ALUResultM;
         mem_wdata = WriteDataM;
      end
   end

   assign StallM = reset & (((state == IDLE) & access & aligned) | (state == REQ) | (state == WAIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         rdata_buf  <= 32'd0;
         timed_out  <= 1'b0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ALUResultW <= 32'd0;
         ReadDataW  <= 32'd0;
         RdW        <= 5'd0;
         MisalignW  <= 1'b0;
         TimeoutW   <= 1'b0;
      end else begin
         MisalignW <= 1'b0;
         TimeoutW  <= 1'b0;
         case (state)
            IDLE: begin
               if (!access || !aligned) begin
                  RegWriteW  <= RegWriteM & ~access;
                  ResultSrcW <= ResultSrcM;
                  ALUResultW <= ALUResultM;
                  RdW        <= RdM;
                  MisalignW  <= access;
               end else begin
                  RegWriteW <= 1'b0;
                  wait_cnt  <= 4'd0;
                  timed_out <= 1'b0;
                  state     <= REQ;
               end
            end
            REQ: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (mem_gnt) begin
                  state <= MemWriteM ? DONE : WAIT;
               end else if (wait_cnt == 4'd15) begin
                  timed_out <= 1'b1;
                  state     <= DONE;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 4'd1;
               if (mem_rvalid) begin
                  rdata_buf <= mem_rdata;
                  state     <= DONE;
               end else if (wait_cnt == 4'd15) begin
                  timed_out <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               RegWriteW  <= RegWriteM & ~timed_out;
               ResultSrcW <= ResultSrcM;
               ALUResultW <= ALUResultM;
               RdW        <= RdM;
               TimeoutW   <= timed_out;
               if (!MemWriteM && !timed_out) begin
                  ReadDataW <= rdata_buf;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/im_stage_ctrl.md
IM_STAGE_CTRL -- requirements
Module: im_stage_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, regardless of clk).
REQ-003 SHALL have inputs RegWriteM, MemWriteM (1 each) and ResultSrcM (2): memory-stage control; ResultSrcM=2'b01 marks a load.
REQ-004 SHALL have inputs ALUResultM (32, address/ALU result), WriteDataM (32, store data) and RdM (5, destination register).
REQ-005 SHALL have outputs mem_req (1), mem_we (1), mem_addr (32) and mem_wdata (32): data-memory request.
REQ-006 SHALL have inputs mem_gnt (1, request accepted), mem_rvalid (1, read data valid) and mem_rdata (32).
REQ-007 SHALL have output StallM (1): holds the IEx/IM registers and everything upstream.
REQ-008 SHALL have registered outputs RegWriteW (1), ResultSrcW (2), ALUResultW (32), ReadDataW (32) and RdW (5): IM/IW pipeline register.
REQ-009 SHALL have registered outputs MisalignW (1) and TimeoutW (1): one-cycle exception flags.

Function
REQ-010 SHALL define access = MemWriteM | (ResultSrcM==2'b01), and aligned = (ALUResultM[1:0]==2'b00); all accesses are 32-bit words.
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-012 IDLE, no access: StallM=0; the W register captures RegWriteM, ResultSrcM, ALUResultM and RdM; ReadDataW holds; stays in IDLE.
REQ-013 IDLE, access and not aligned: no memory request; StallM=0; next cycle MisalignW=1 and RegWriteW=0, with the other W fields captured; stays in IDLE.
REQ-014 IDLE, access and aligned: StallM=1; next state REQ; next cycle RegWriteW=0 (bubble).
REQ-015 REQ: mem_req=1; mem_we=MemWriteM; mem_addr=ALUResultM; mem_wdata=WriteDataM; StallM=1; on mem_gnt, store -> DONE and load -> WAIT.
REQ-016 WAIT: mem_req=0; StallM=1; on mem_rvalid, capture mem_rdata into an internal buffer and go to DONE; mem_rvalid outside WAIT SHALL be ignored.
REQ-017 DONE: StallM=0; the W register captures the M control fields and ALUResultM; ReadDataW takes the buffer for a load and holds for a store; next state IDLE.
REQ-018 mem_req, mem_we, mem_addr and mem_wdata SHALL be 0 in every state except REQ.
REQ-019 SHALL keep a 4-bit wait counter: cleared on entry to REQ; increments each cycle in REQ or WAIT.
REQ-020 Counter at 15 with no gnt/rvalid that cycle: go to DONE; DONE then writes RegWriteW=0 and TimeoutW=1; a later gnt/rvalid for the aborted access is ignored.
REQ-021 gnt/rvalid in the same cycle the counter reaches 15: completion wins, no timeout.
REQ-022 Upstream holds the M inputs stable while StallM=1; the block does not latch them before DONE.
REQ-023 Minimum occupancy of an aligned access: store 3 cycles (IDLE, REQ, DONE); load 4 cycles (IDLE, REQ, WAIT, DONE) with zero-wait memory.
REQ-024 MisalignW and TimeoutW SHALL be high for exactly one cycle per event, else 0.

Reset
REQ-025 reset=0 SHALL force state IDLE, counter 0, data buffer 0, all W outputs 0, MisalignW=TimeoutW=0, mem_req=mem_we=0, mem_addr=mem_wdata=0, and StallM=0.
REQ-026 Reset during REQ/WAIT SHALL abort the access with no W update; after release the FSM starts in IDLE.

Verification
REQ-027 Non-memory op RegWriteM=1, ResultSrcM=00, ALUResultM=0x10, RdM=5 -> next cycle RegWriteW=1, ALUResultW=0x10, RdW=5, StallM never high.
REQ-028 Load at 0x100, gnt on first REQ cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> StallM high 4 cycles; after DONE RegWriteW=1, ResultSrcW=01, ReadDataW=0xDEADBEEF.
REQ-029 Store at 0x200 of 0x12345678 with immediate gnt -> exactly one cycle of mem_req=1, mem_we=1, addr 0x200, wdata 0x12345678; StallM high 2 cycles.
REQ-030 Load at 0x103 -> mem_req stays 0; next cycle MisalignW=1, RegWriteW=0.
REQ-031 Load at 0x100 with gnt never asserted -> TimeoutW=1 after 16 wait cycles, RegWriteW=0, FSM back to IDLE.
REQ-032 reset=0 asserted mid-WAIT, then rvalid pulsed -> all outputs 0 immediately, rvalid ignored, normal operation after release.
